// File: rtl/reg_bus_master.sv
// reg_bus_master: turns word-level client commands into single-cycle we/re
// strobes on the register/page-RAM slave bus. Each strobe is exactly one slave
// access, so FIFO registers (TDR/RDR) push/pop once per strobe.
// Build option REG_MASTER_BURST_EN: when defined, cmd_len/cmd_inc give
// multi-word incrementing or fixed-address bursts; when undefined every
// command is a single word and no address/length counters are built.
module reg_bus_master #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rnw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_inc,
    // write data stream
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    // read data stream
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    // status
    output logic              busy,
    output logic              done,
    // slave bus
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              re,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic              accept;     // command handshake this cycle
    logic              beat;       // one slave access (we or re) this cycle
    logic              last_word;  // current beat is the final word of the command

    assign accept     = cmd_valid && cmd_ready;
    assign addr       = cur_addr;
    assign write_data = wr_data;
    assign busy       = (state != ST_IDLE);

    // State register; reset abandons any command and drops strobes at once
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking (<=) so every
        // register samples the pre-edge values; combinational logic uses =.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        beat      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_rnw ? ST_RD : ST_WR;
                end
            end
            ST_WR: begin
                we       = wr_valid;
                wr_ready = wr_valid;
                beat     = wr_valid;
                if (beat && last_word) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD: begin
                // Only pop the slave when the holding register can take the word
                re   = !rd_valid || rd_ready;
                beat = re;
                if (beat && last_word) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef REG_MASTER_BURST_EN
    logic [LEN_W-1:0] cnt;  // words remaining minus one
    logic             inc;  // step address per beat

    assign last_word = (cnt == '0);

    // Burst bookkeeping: load on accept, step on every beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr <= '0;
            cnt      <= '0;
            inc      <= 1'b0;
        end else if (accept) begin
            cur_addr <= cmd_addr;
            cnt      <= cmd_len;
            inc      <= cmd_inc;
        end else if (beat) begin
            cur_addr <= cur_addr + {{(ADDR_W-1){1'b0}}, inc};
            cnt      <= cnt - LEN_W'(1);
        end
    end
`else
    logic unused_burst_fields;

    assign last_word           = 1'b1;
    assign unused_burst_fields = ^{cmd_len, cmd_inc};

    // Single-word commands: the address is just held from accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr <= '0;
        end else if (accept) begin
            cur_addr <= cmd_addr;
        end
    end
`endif

    // Read holding register: capture on re, release on client handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (re) begin
            rd_valid <= 1'b1;
            rd_data  <= read_data;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

    // Completion pulse in the cycle after the last strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= beat && last_word;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: directed scenarios plus randomized
// commands, checked against a word-list reference model and a slave model
// whose read value encodes address and pop order.
module tb_reg_bus_master;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 10;
    localparam int LIMIT  = 4000;
`ifdef REG_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rnw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_inc;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              re;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pops     = 0;

    // observed bus activity, appended by the monitor
    logic [ADDR_W-1:0] we_addr_q[$];
    logic [DATA_W-1:0] we_data_q[$];
    int                we_cyc_q[$];
    logic [ADDR_W-1:0] re_addr_q[$];
    int                re_cyc_q[$];
    logic [DATA_W-1:0] rd_q[$];
    int                done_cyc_q[$];
    int                busy_total    = 0;
    int                viol_total    = 0;
    int                lat_err_total = 0;
    logic              prev_re       = 1'b0;
    logic [DATA_W-1:0] prev_word     = '0;

    reg_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_inc(cmd_inc),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .addr(addr), .we(we), .re(re), .write_data(write_data), .read_data(read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: each read value carries its address and its pop index
    function automatic logic [DATA_W-1:0] slave_word(input logic [ADDR_W-1:0] a, input int pop);
        logic [9:0] p;
        p = pop[9:0];
        return {p, a} ^ 32'hA5A5_0004;
    endfunction

    assign read_data = re ? slave_word(addr, pops) : 32'hDEAD_BEEF;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst_n && re) pops <= pops + 1;

    // Monitor: log strobes/handshakes and count protocol violations
    always @(negedge clk) begin
        if (rst_n) begin
            if (we) begin
                we_addr_q.push_back(addr);
                we_data_q.push_back(write_data);
                we_cyc_q.push_back(cyc);
            end
            if (re) begin
                re_addr_q.push_back(addr);
                re_cyc_q.push_back(cyc);
            end
            if (rd_valid && rd_ready) rd_q.push_back(rd_data);
            if (done) done_cyc_q.push_back(cyc);
            if (busy) busy_total <= busy_total + 1;
            if ((we && re) || ((we || re) && !busy) || (re && rd_valid && !rd_ready) || (we && !wr_valid))
                viol_total <= viol_total + 1;
            if (prev_re && !(rd_valid === 1'b1 && rd_data === prev_word))
                lat_err_total <= lat_err_total + 1;
            prev_re   <= re;
            prev_word <= read_data;
        end else begin
            prev_re <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word k of a command goes to start + k*inc modulo 2^ADDR_W
    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] a, input int k, input bit inc);
        longint step;
        step = inc ? longint'(k) : 64'd0;
        return ADDR_W'((longint'(a) + step) % (64'd1 << ADDR_W));
    endfunction

    function automatic int words_of(input int len);
        return BURST ? len + 1 : 1;
    endfunction

    // Offer a command and return the cycle in which it was accepted
    task automatic issue(input bit rnw, input logic [ADDR_W-1:0] a, input int len,
                         input bit inc, output int acc);
        int guard;
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = a;
        cmd_len   = LEN_W'(len);
        cmd_inc   = inc;
        guard     = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_accept", cmd_ready, 1);
        acc = cyc;
        @(posedge clk);
        #1;
        // scramble the command fields so late sampling would be visible
        cmd_valid = 1'b0;
        cmd_rnw   = ($urandom_range(0, 1) == 1);
        cmd_addr  = ADDR_W'($urandom);
        cmd_len   = LEN_W'($urandom);
        cmd_inc   = ~inc;
    endtask

    task automatic run_write(input string tag, input logic [ADDR_W-1:0] a, input int len,
                             input bit inc, input bit stall, input logic [DATA_W-1:0] d0);
        int n, idx, guard, acc, b_we, b_done, b_busy, b_viol;
        logic [DATA_W-1:0] wd[$];
        n = words_of(len);
        wd.push_back(d0);
        for (int k = 1; k < n; k++) wd.push_back($urandom);
        b_we   = we_addr_q.size();
        b_done = done_cyc_q.size();
        b_busy = busy_total;
        b_viol = viol_total;
        wr_valid = !stall;
        wr_data  = wd[0];
        issue(1'b0, a, len, inc, acc);
        idx   = 0;
        guard = 0;
        while ((idx < n || done_cyc_q.size() == b_done) && guard < LIMIT) begin
            if (idx < n) begin
                wr_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                wr_data  = wd[idx];
            end else begin
                wr_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
                wr_data  = $urandom;
            end
            @(negedge clk);
            if (wr_valid && wr_ready) idx++;
            @(posedge clk);
            #1;
            guard++;
        end
        wr_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_timeout"}, guard < LIMIT, 1);
        check({tag, "_we_count"}, we_addr_q.size() - b_we, n);
        for (int k = 0; k < n && b_we + k < we_addr_q.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), we_addr_q[b_we+k], exp_addr(a, k, inc));
            check($sformatf("%s_data%0d", tag, k), we_data_q[b_we+k], wd[k]);
        end
        check({tag, "_done_count"}, done_cyc_q.size() - b_done, 1);
        if (done_cyc_q.size() > b_done && we_addr_q.size() >= b_we + n)
            check({tag, "_done_timing"}, done_cyc_q[b_done], we_cyc_q[b_we+n-1] + 1);
        if (!stall) begin
            if (we_cyc_q.size() > b_we) check({tag, "_first_strobe"}, we_cyc_q[b_we], acc + 1);
            check({tag, "_busy_cycles"}, busy_total - b_busy, n);
        end
        check({tag, "_protocol"}, viol_total - b_viol, 0);
    endtask

    // mode 0: rd_ready held high; 1: random rd_ready; 2: rd_ready low 3 cycles after first word
    task automatic run_read(input string tag, input logic [ADDR_W-1:0] a, input int len,
                            input bit inc, input int mode);
        int n, guard, acc, b_re, b_rd, b_done, b_busy, b_viol, b_lat, pop0, low_left;
        bit hold_started;
        n      = words_of(len);
        b_re   = re_addr_q.size();
        b_rd   = rd_q.size();
        b_done = done_cyc_q.size();
        b_busy = busy_total;
        b_viol = viol_total;
        b_lat  = lat_err_total;
        pop0   = pops;
        rd_ready = (mode != 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
        issue(1'b1, a, len, inc, acc);
        guard        = 0;
        hold_started = 1'b0;
        low_left     = 3;
        while ((rd_q.size() - b_rd < n || done_cyc_q.size() == b_done) && guard < LIMIT) begin
            if (mode == 1) begin
                rd_ready = ($urandom_range(0, 1) == 1);
            end else if (mode == 2) begin
                if (rd_valid && !hold_started) hold_started = 1'b1;
                if (hold_started && low_left > 0) begin
                    rd_ready = 1'b0;
                    low_left--;
                end else begin
                    rd_ready = 1'b1;
                end
            end else begin
                rd_ready = 1'b1;
            end
            @(negedge clk);
            @(posedge clk);
            #1;
            guard++;
        end
        rd_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_timeout"}, guard < LIMIT, 1);
        check({tag, "_re_count"}, re_addr_q.size() - b_re, n);
        for (int k = 0; k < n && b_re + k < re_addr_q.size(); k++)
            check($sformatf("%s_addr%0d", tag, k), re_addr_q[b_re+k], exp_addr(a, k, inc));
        check({tag, "_rd_count"}, rd_q.size() - b_rd, n);
        for (int k = 0; k < n && b_rd + k < rd_q.size(); k++)
            check($sformatf("%s_word%0d", tag, k), rd_q[b_rd+k], slave_word(exp_addr(a, k, inc), pop0 + k));
        check({tag, "_done_count"}, done_cyc_q.size() - b_done, 1);
        if (done_cyc_q.size() > b_done && re_addr_q.size() >= b_re + n)
            check({tag, "_done_timing"}, done_cyc_q[b_done], re_cyc_q[b_re+n-1] + 1);
        if (mode == 0) begin
            if (re_cyc_q.size() > b_re) check({tag, "_first_strobe"}, re_cyc_q[b_re], acc + 1);
            check({tag, "_busy_cycles"}, busy_total - b_busy, n);
        end
        check({tag, "_protocol"}, viol_total - b_viol, 0);
        check({tag, "_rd_latency"}, lat_err_total - b_lat, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n8, b_done, b_re, b_rd, pop0, guard;
        logic [ADDR_W-1:0] ra;
        int rl;
        bit ri;

        // reset with a write word already offered: nothing may strobe
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_rnw   = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_inc   = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 32'h1234_5678;
        rd_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_addr", addr, 0);
        check("rst_we", we, 0);
        check("rst_re", re, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_ready = 1'b1;

        // single write and single read from the test plan
        run_write("wr_single", 22'h000000, 0, 1'b1, 1'b0, 32'h0000_C000);
        b_rd = rd_q.size();
        run_read("rd_single", 22'h000005, 0, 1'b1, 0);
        check("rd_single_value", (rd_q.size() > b_rd) ? rd_q[b_rd] : 32'hx, 32'hA5A5_0001);

        // long incrementing write, fixed-address stalled read, address wrap
        run_write("wr_burst1024", 22'h001000, 1023, 1'b1, 1'b0, $urandom);
        run_read("rd_fixed_stall", 22'h000003, 3, 1'b0, 2);
        run_write("wr_wrap", 22'h3FFFFE, 3, 1'b1, 1'b0, $urandom);
        run_read("rd_wrap", 22'h3FFFFF, 2, 1'b1, 0);

        // a word left pending in IDLE must hold off the next read's strobe
        rd_ready = 1'b0;
        b_re = re_addr_q.size();
        b_rd = rd_q.size();
        pop0 = pops;
        issue(1'b1, 22'h000020, 0, 1'b0, acc);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("hold_idle_rd_valid", rd_valid, 1);
        check("hold_idle_busy", busy, 0);
        issue(1'b1, 22'h000021, 0, 1'b0, acc);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("hold_gated_busy", busy, 1);
        check("hold_gated_re_count", re_addr_q.size() - b_re, 1);
        rd_ready = 1'b1;
        guard = 0;
        while (rd_q.size() - b_rd < 2 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("hold_timeout", guard < 50, 1);
        check("hold_word0", (rd_q.size() > b_rd) ? rd_q[b_rd] : 32'hx, slave_word(22'h000020, pop0));
        check("hold_word1", (rd_q.size() > b_rd + 1) ? rd_q[b_rd+1] : 32'hx, slave_word(22'h000021, pop0 + 1));
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // reset during beat 5 of an 8-word write
        n8 = words_of(7);
        wr_valid = 1'b1;
        wr_data  = 32'hCAFE_0005;
        issue(1'b0, 22'h000200, 7, 1'b1, acc);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("midrst_pre_we", we, n8 >= 5);
        check("midrst_pre_addr", addr, BURST ? 22'h000204 : 22'h000200);
        b_done = done_cyc_q.size();
        rst_n = 1'b0;
        #1;
        check("midrst_we_async", we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_addr", addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("midrst_no_done", done_cyc_q.size() - b_done, 0);
        check("midrst_idle_ready", cmd_ready, 1);
        check("midrst_idle_busy", busy, 0);

        // randomized commands with random stalls
        for (int i = 0; i < 14; i++) begin
            ra = ADDR_W'($urandom);
            if (i % 4 == 3) ra = 22'h3FFFF8 + ADDR_W'($urandom_range(0, 7));
            rl = $urandom_range(0, 15);
            ri = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1)
                run_read($sformatf("rnd%0d_rd", i), ra, rl, ri, 1);
            else
                run_write($sformatf("rnd%0d_wr", i), ra, rl, ri, 1'b1, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Bus initiator for the FPGA register/page-RAM slave bus (`addr`/`we`/`re`/`write_data`/`read_data`). It accepts word-level commands from an internal client, such as the second core's bridge or a page-copy engine, and converts them into single-cycle `we`/`re` strobes. Each strobe performs exactly one slave access, which matters for FIFO registers (TDR/RDR), where every `re` pops and every `we` pushes. It supports incrementing and fixed-address bursts and returns read data through a valid/ready stream.

## Interface
- `ADDR_W`, 22, slave word-address width
- `DATA_W`, 32, data width
- `LEN_W`, 10, burst length field width (length = `cmd_len`+1, max 1024 words)

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_rnw`  in  1  1 = read, 0 = write
- `cmd_addr`  in  ADDR_W  start word address
- `cmd_len`  in  LEN_W  words minus one
- `cmd_inc`  in  1  1 = increment address per word, 0 = fixed (FIFO port)
- `wr_valid`  in  1  write word available
- `wr_ready`  out  1  write word consumed this cycle
- `wr_data`  in  DATA_W  write word
- `rd_valid`  out  1  `rd_data` valid
- `rd_ready`  in  1  client takes `rd_data`
- `rd_data`  out  DATA_W  captured read word
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse after last word of a command
- `addr`  out  ADDR_W  slave address
- `we`  out  1  slave write strobe
- `re`  out  1  slave read strobe
- `write_data`  out  DATA_W  slave write data
- `read_data`  in  DATA_W  slave read data (combinational from `re`/`addr` on the slave side)

## Operation
- States: IDLE, WR, RD.
- IDLE: `cmd_ready`=1. On accept:
  - `cur_addr`←`cmd_addr`, `cnt`←`cmd_len`, `inc`←`cmd_inc`.
  - Go to RD if `cmd_rnw`, else WR.
- Outputs in every state: `addr`=`cur_addr` (registered); `write_data`=`wr_data` (pass-through); `busy`=(state≠IDLE).
- WR:
  - `we`=`wr_ready`=`wr_valid`.
  - Per beat: `cur_addr`+=`inc` (modulo 2^ADDR_W), `cnt`−=1.
  - Beat with `cnt`==0: go to IDLE, pulse `done` next cycle.
- RD:
  - `re` = `!rd_valid || rd_ready`.
  - On `re` beat, capture `read_data` into `rd_data` at the same edge and set `rd_valid`.
  - Address/count update as in WR; last beat goes to IDLE with `done` pulse.
- `rd_valid` clears on `rd_ready` when there is no new beat. A stalled read never issues `re`, so no FIFO word is lost.
- `rd_valid` may remain set in IDLE. A new read command waits on the same gating.
- `we` and `re` are never asserted together, and never asserted outside WR/RD.
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0, `addr`=0, `we`=0, `re`=0.
- Reset mid-command: the command is abandoned immediately and strobes drop asynchronously. No `done` is issued.

## Timing
- Command accept to first strobe: 1 cycle (strobe in the cycle after acceptance).
- Throughput: 1 word/cycle when `wr_valid` is held high or `rd_ready` is held high.
- Read data: `re` in cycle N, `rd_valid`/`rd_data` in cycle N+1.
- `done` rises in the cycle after the last strobe; `busy` falls in that same cycle; `cmd_ready` returns in that same cycle.
- Burst of L words with no stalls: `busy` is high for exactly L cycles.

## Configuration
- `REG_MASTER_BURST_EN` defined: `cmd_len` and `cmd_inc` are honoured as described above.
- `REG_MASTER_BURST_EN` undefined:
  - `cmd_len` and `cmd_inc` are ignored.
  - Every command is exactly one word.
  - No address counter or length counter is built.
  - All other timing is unchanged.

## Test plan
- Single write, addr 0x000000, data 0x0000C000, `wr_valid` high → exactly one `we` cycle with `addr`=0x000000 and `write_data`=0x0000C000; `done` the next cycle.
- Single read, addr 0x000005, slave returns 0xA5A5_0001 → one `re` cycle; next cycle `rd_valid`=1 and `rd_data`=0xA5A5_0001.
- Incrementing write burst, addr 0x1000, `cmd_len`=1023 → 1024 `we` beats, addresses 0x1000..0x13FF, one `done`, 1024 `busy` cycles.
- Fixed-address read burst, addr 0x000003, `cmd_len`=3, `rd_ready` low for 3 cycles after the first word → `re` is never high while `rd_valid && !rd_ready`; exactly 4 `re` pulses, all at `addr` 0x000003; 4 words delivered in order.
- Address wrap, addr 0x3FFFFE, `cmd_len`=3, incrementing → addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
- `rst_n` low during beat 5 of an 8-word write → `we`=0 immediately; after release, state is IDLE, `cmd_ready`=1, no `done`.
